dft_scan_responder: RTL

//  Per-chain responder for the DFT scan-readout handshake driven by the prewrapper control unit.
//  - Accepts a scan request and acknowledges it.
//  - Shifts one DUT scan chain out non-destructively, recirculating it back in.
//  - Packs the bits into 32-bit words and strobes each word out.
//  - Commits and waits for the commit ack.
//  One instance per chain; p_sc_nbr instances sit between the control unit and the DUT scan ports.

---
 rtl/dft_scan_responder_pkg.sv | 15 +
 rtl/dft_scan_responder_counter.sv | 38 +++
 rtl/dft_scan_responder.sv | 135 +++++++++++++
 3 files changed

// File: rtl/dft_scan_responder_pkg.sv
// Shared definitions for the per-chain DFT scan-readout responder:
// FSM state encoding and the packed output word width.
package dft_scan_responder_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACK    = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_COMMIT = 3'd4
  } state_e;

endpackage

// File: rtl/dft_scan_responder_counter.sv
// Shift counter for one scan chain: counts shifted bits and flags the last one.
// Saturates at p_max so it never wraps within an operation.
module dft_scan_responder_counter
  import dft_scan_responder_pkg::*;
#(
  parameter int unsigned p_max   = 100,
  parameter int unsigned p_width = $clog2(p_max + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic cnten_i,
  output logic ov_o
);

  logic [p_width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (cnten_i && (cnt_q != p_width'(p_max))) begin
      cnt_d = cnt_q + p_width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // High while the bit being shifted this cycle is the chain's last one
  assign ov_o = (cnt_q == p_width'(p_max - 1));

endmodule

// File: rtl/dft_scan_responder.sv
// Per-chain scan responder: acknowledges a request, rotates the DUT chain once
// while packing its bits LSB-first into 32-bit strobed words, then commits.
module dft_scan_responder
  import dft_scan_responder_pkg::*;
#(
  parameter int unsigned p_chain_len = 100,
  parameter int unsigned p_word_w    = WORD_W
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dft_val_op_i,
  output logic                dft_op_ack_o,
  output logic                dft_op_commit_o,
  input  logic                dft_commit_ack_i,
  output logic                dft_output_strobe_o,
  output logic [p_word_w-1:0] dft_output_data_o,
  output logic                scan_en_o,
  input  logic                scan_out_i,
  output logic                scan_in_o
);

  localparam int unsigned IDX_W   = $clog2(p_word_w);
  localparam int unsigned CNT_W   = $clog2(p_chain_len + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(p_word_w - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    bit_idx_q, bit_idx_d;
  logic [p_word_w-1:0] word_q, word_d, word_fill;
  logic [p_word_w-1:0] data_q, data_d;
  logic                ack_q, ack_d;
  logic                commit_q, commit_d;
  logic                scan_en_q, scan_en_d;
  logic                strobe_q, strobe_d;
  logic                last_bit;
  logic                cnt_clr, cnt_en;

  dft_scan_responder_counter #(
    .p_max   (p_chain_len),
    .p_width (CNT_W)
  ) u_shift_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (cnt_clr),
    .cnten_i (cnt_en),
    .ov_o    (last_bit)
  );

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    word_d    = word_q;
    data_d    = '0;
    strobe_d  = 1'b0;
    cnt_clr   = (state_q == ST_IDLE);
    cnt_en    = (state_q == ST_SHIFT);
    word_fill = word_q;
    word_fill[bit_idx_q] = scan_out_i;

    case (state_q)
      ST_IDLE: begin
        bit_idx_d = '0;
        word_d    = '0;
        if (dft_val_op_i) begin
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        // Wait for the request to drop so skewed chains all start cleanly
        if (!dft_val_op_i) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        word_d    = word_fill;
        bit_idx_d = (bit_idx_q == IDX_LAST) ? '0 : bit_idx_q + IDX_W'(1);
        // Full word or final partial word: present it next cycle, restart packing
        if ((bit_idx_q == IDX_LAST) || last_bit) begin
          strobe_d = 1'b1;
          data_d   = word_fill;
          word_d   = '0;
        end
        if (last_bit) begin
          bit_idx_d = '0;
          state_d   = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        if (dft_commit_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ack_d     = (state_d == ST_ACK);
    commit_d  = (state_d == ST_COMMIT);
    scan_en_d = (state_d == ST_SHIFT);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= '0;
      word_q    <= '0;
      data_q    <= '0;
      ack_q     <= 1'b0;
      commit_q  <= 1'b0;
      scan_en_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      word_q    <= word_d;
      data_q    <= data_d;
      ack_q     <= ack_d;
      commit_q  <= commit_d;
      scan_en_q <= scan_en_d;
      strobe_q  <= strobe_d;
    end
  end

  assign dft_op_ack_o        = ack_q;
  assign dft_op_commit_o     = commit_q;
  assign dft_output_strobe_o = strobe_q;
  assign dft_output_data_o   = data_q;
  assign scan_en_o           = scan_en_q;
  // Recirculate so the chain is restored after a full rotation
  assign scan_in_o           = scan_en_q & scan_out_i;

endmodule
